// File: rtl/address_generator_w.sv
// Write-side AHB address generator: walks the output image row-major, one word per enable,
// haddr_w valid the cycle after start_w. Optional config check enabled by ADDR_GEN_W_CFG_CHECK_EN.
module address_generator_w #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start_w,
  input  logic [ADDR_W-1:0] base_addr_w,
  input  logic [DIM_W-1:0]  length,
  input  logic [DIM_W-1:0]  width,
  input  logic              addr_update_enable_w,
  output logic [ADDR_W-1:0] haddr_w,
  output logic              plus4_w,
  output logic              busy_w,
  output logic              frame_done_w,
  output logic              err_w
);

`ifdef ADDR_GEN_W_CFG_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE, S_ERROR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  len_q, len_d;
  logic [DIM_W-1:0]  wid_q, wid_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  logic [DIM_W-1:0]  last_col;
  logic              at_last_col;
  logic              cfg_bad;

  assign last_col    = len_q - DIM_W'(4);
  assign at_last_col = (col_q == last_col);

`ifdef ADDR_GEN_W_CFG_CHECK_EN
  assign cfg_bad = (base_addr_w[1:0] != 2'b00) || (length[1:0] != 2'b00) ||
                   (length == '0) || (width == '0);
`else
  assign cfg_bad = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      len_q      <= '0;
      wid_q      <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      len_q      <= len_d;
      wid_q      <= wid_d;
      row_base_q <= row_base_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    len_d      = len_q;
    wid_d      = wid_q;
    row_base_d = row_base_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_w) begin
          len_d      = length;
          wid_d      = width;
          col_d      = '0;
          row_d      = '0;
          row_base_d = base_addr_w;
`ifdef ADDR_GEN_W_CFG_CHECK_EN
          state_d    = cfg_bad ? S_ERROR : S_ACTIVE;
`else
          state_d    = S_ACTIVE;
`endif
        end
      end
      S_ACTIVE: begin
        if (addr_update_enable_w) begin
          if (!at_last_col) begin
            col_d = col_q + DIM_W'(4);
          end else if (row_q != wid_q - DIM_W'(1)) begin
            col_d      = '0;
            row_d      = row_q + DIM_W'(1);
            row_base_d = row_base_q + ADDR_W'(len_q);
          end else begin
            // counters freeze so DONE still presents the final address
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef ADDR_GEN_W_CFG_CHECK_EN
      S_ERROR: begin
        if (start_w) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    haddr_w      = '0;
    plus4_w      = 1'b0;
    busy_w       = 1'b0;
    frame_done_w = 1'b0;
    err_w        = 1'b0;
    if (state_q == S_ACTIVE || state_q == S_DONE)
      haddr_w = row_base_q + ADDR_W'(col_q);
    if (state_q == S_ACTIVE) begin
      plus4_w = at_last_col;
      busy_w  = 1'b1;
    end
    if (state_q == S_DONE)
      frame_done_w = 1'b1;
`ifdef ADDR_GEN_W_CFG_CHECK_EN
    if (state_q == S_ERROR)
      err_w = 1'b1;
`endif
  end

  logic unused_ok;
  assign unused_ok = cfg_bad;

endmodule

// File: doc/address_generator_w.md
Name: address_generator_w

Overview:
- Write-side address generator for the AHB master: produces the write address for every processed output word, walking row-major through the output image.
- Mirror of the read-side column counter, extended with row tracking, start/done handshake and frame sequencing.
- Sits between the write-data controller (which pulses one enable per accepted AHB write beat) and the HADDR mux of the AHB master.

Parameters:
- ADDR_W, 32, width of base address and generated address.
- DIM_W, 16, width of the length (bytes per row) and width (rows per frame) inputs.

Ports:
- HCLK  input  1  system clock, all logic on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- start_w  input  1  one-cycle request to begin a frame; honoured only in IDLE.
- base_addr_w  input  ADDR_W  byte address of first output word; sampled on accepted start_w.
- length  input  DIM_W  bytes per row (multiple of 4); sampled on accepted start_w.
- width  input  DIM_W  rows per frame; sampled on accepted start_w.
- addr_update_enable_w  input  1  current address consumed; advance by one word.
- haddr_w  output  ADDR_W  current write address.
- plus4_w  output  1  current address is the last word of a row.
- busy_w  output  1  frame in progress (ACTIVE state).
- frame_done_w  output  1  one-cycle pulse after the final word is consumed.
- err_w  output  1  illegal configuration flag (only with optional feature; tied 0 otherwise).

Behaviour:
- Reset (HRESET=1 at a clock edge): state IDLE; haddr_w=0, plus4_w=0, busy_w=0, frame_done_w=0, err_w=0; column and row counters and latched length/width/base cleared. Reset mid-frame aborts the frame; no frame_done_w pulse.
- States: IDLE, ACTIVE, DONE (plus ERROR with the optional feature).
- IDLE: on start_w=1, latch base/length/width, col=0, row=0, row_base=base, and enter ACTIVE next cycle. haddr_w=base and busy_w=1 in the first ACTIVE cycle (1-cycle latency from start_w).
- IDLE: addr_update_enable_w is ignored.
- ACTIVE: haddr_w = row_base + col, arithmetic modulo 2^ADDR_W.
- ACTIVE: plus4_w = (col == length_lat − 4), combinational from registered state.
- ACTIVE: start_w is ignored.
- ACTIVE: on addr_update_enable_w=1 with plus4_w=0: col += 4.
- ACTIVE: on addr_update_enable_w=1 with plus4_w=1 and row != width_lat−1: col=0, row += 1, row_base += length_lat.
- ACTIVE: on addr_update_enable_w=1 with plus4_w=1 and row == width_lat−1: go to DONE.
- DONE (one cycle): frame_done_w=1, busy_w=0, haddr_w holds the last address. Then IDLE unconditionally; start_w in DONE is ignored.
- Without enables, ACTIVE holds all values indefinitely.
- Single-word row (length_lat=4): plus4_w is high for every word.
- Single-row frame (width_lat=1): DONE follows the last column.
- Counters: col is DIM_W bits; row is DIM_W bits; row_base is ADDR_W bits. length_lat−4 is computed in DIM_W bits.

Optional Feature:
- Macro: ADDR_GEN_W_CFG_CHECK_EN
- Defined: on accepted start_w, if base_addr_w[1:0]!=0, length[1:0]!=0, length==0 or width==0, enter ERROR instead of ACTIVE.
  - ERROR: err_w=1, busy_w=0, haddr_w=0, plus4_w=0; enables ignored.
  - ERROR exits to IDLE on the next start_w, which is not itself accepted as a frame start. HRESET also clears it.
- Not defined: no ERROR state, err_w tied 0; behaviour with illegal configuration is unspecified.

Test Plan:
- Basic frame: base=0x1000, length=8, width=3, start then continuous enables.
  - haddr_w sequence: 0x1000, 0x1004, 0x1008, 0x100C, 0x1010, 0x1014.
  - plus4_w high on 0x1004, 0x100C and 0x1014.
  - frame_done_w pulses exactly once, one cycle after the 6th enable; back in IDLE the following cycle.
- Gapped enables: same configuration, enable every 3rd cycle. Same address sequence, with haddr_w stable between enables; busy_w high throughout ACTIVE.
- Degenerate sizes: length=4, width=1, base=0xFFFF_FFFC.
  - haddr_w=0xFFFF_FFFC with plus4_w=1.
  - One enable leads to DONE.
- Address wrap: base=0xFFFF_FFF8, length=8, width=2. Sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Ignored inputs and mid-frame reset: start_w asserted during ACTIVE, enables asserted in IDLE and DONE.
  - No effect on the address sequence.
  - HRESET after the 2nd enable: all outputs 0 next cycle and no frame_done_w pulse.
  - A new start_w then begins cleanly at the new base.
- With ADDR_GEN_W_CFG_CHECK_EN: start with base=0x1002.
  - err_w=1 and busy_w=0 the next cycle.
  - The next start_w returns the block to IDLE with err_w=0.
  - A following start_w with base=0x2000, length=4, width=1 runs normally.
